// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU,
// branch resolution/target and the EX/MEM pipeline register.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              result_src;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] write_data;
        logic [DATA_W-1:0] alu_result;
    } ex_mem_t;

    ex_mem_t           ex_mem_q;
    ex_mem_t           ex_mem_d;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              lt_signed;
    logic              lt_unsigned;

    // Forwarding: ALU_ResultM is the registered EX/MEM value, so no comb loop.
    always_comb begin
        src_a = RD1_E;
        unique case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ex_mem_q.alu_result;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        unique case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ex_mem_q.alu_result;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b       = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign lt_signed   = $signed(src_a) < $signed(src_b);
    assign lt_unsigned = src_a < src_b;

    always_comb begin
        alu_result = '0;
        unique case (ALUControlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
            default:  alu_result = '0;
        endcase
    end

    assign alu_zero  = (alu_result == '0);
    assign PCSrcE    = BranchE & alu_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.rd         = RD_E;
        ex_mem_d.pc_plus4   = PCPlus4E;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.alu_result = alu_result;
    end

    // EX/MEM register; reset discards any in-flight content.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign RegWriteM   = ex_mem_q.reg_write;
    assign MemWriteM   = ex_mem_q.mem_write;
    assign ResultSrcM  = ex_mem_q.result_src;
    assign RD_M        = ex_mem_q.rd;
    assign PCPlus4M    = ex_mem_q.pc_plus4;
    assign WriteDataM  = ex_mem_q.write_data;
    assign ALU_ResultM = ex_mem_q.alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed table-driven bench for execute_cycle plus reset corner sequences.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int total = 0;
    int bad   = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        alusrc;
        logic [2:0]  ctrl;
        logic        br, rw, mw, rs;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2, imm, pc, pc4, resw;
        logic        exp_pcsrc;
        logic [31:0] exp_target, exp_alu, exp_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
        input logic [2:0] ctrl, input logic br, input logic rw, input logic mw,
        input logic rs, input logic [4:0] rd, input logic [31:0] rd1,
        input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
        input logic [31:0] pc4, input logic [31:0] resw, input logic exp_pcsrc,
        input logic [31:0] exp_target, input logic [31:0] exp_alu,
        input logic [31:0] exp_wd);
        vec_t v;
        v.fa = fa; v.fb = fb; v.alusrc = alusrc; v.ctrl = ctrl; v.br = br;
        v.rw = rw; v.mw = mw; v.rs = rs; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2;
        v.imm = imm; v.pc = pc; v.pc4 = pc4; v.resw = resw;
        v.exp_pcsrc = exp_pcsrc; v.exp_target = exp_target;
        v.exp_alu = exp_alu; v.exp_wd = exp_wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, " RegWriteM"}, 32'(RegWriteM), 32'h0);
        check({tag, " MemWriteM"}, 32'(MemWriteM), 32'h0);
        check({tag, " ResultSrcM"}, 32'(ResultSrcM), 32'h0);
        check({tag, " RD_M"}, 32'(RD_M), 32'h0);
        check({tag, " PCPlus4M"}, PCPlus4M, 32'h0);
        check({tag, " WriteDataM"}, WriteDataM, 32'h0);
        check({tag, " ALU_ResultM"}, ALU_ResultM, 32'h0);
    endtask

    task automatic apply(input vec_t v);
        ForwardA_E = v.fa; ForwardB_E = v.fb; ALUSrcE = v.alusrc;
        ALUControlE = v.ctrl; BranchE = v.br; RegWriteE = v.rw;
        MemWriteE = v.mw; ResultSrcE = v.rs; RD_E = v.rd; RD1_E = v.rd1;
        RD2_E = v.rd2; Imm_Ext_E = v.imm; PCE = v.pc; PCPlus4E = v.pc4;
        ResultW = v.resw;
    endtask

    task automatic randomize_inputs();
        RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
        ResultSrcE = 1'($urandom); BranchE = 1'($urandom); ALUControlE = 3'($urandom);
        RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; RD_E = 5'($urandom);
        PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
        ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
    endtask

    initial begin
        vec_t v;

        // fa fb src ctrl br rw mw rs rd rd1 rd2 imm pc pc4 resw | pcsrc target alu wd
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7,
            32'd5, 32'd3, 32'd0, 32'h0, 32'h4, 32'h0, 1'b0, 32'h0, 32'd8, 32'd3));
        vecs.push_back(mk(2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8,
            32'd5, 32'd3, 32'd3, 32'h20, 32'h24, 32'h0, 1'b0, 32'h23, 32'd8, 32'd3));
        vecs.push_back(mk(2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,
            32'd8, 32'd2, 32'd0, 32'h40, 32'h44, 32'hA, 1'b0, 32'h40, 32'hC, 32'd2));
        vecs.push_back(mk(2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10,
            32'd1, 32'd1, 32'd0, 32'h44, 32'h48, 32'h0, 1'b0, 32'h44, 32'h18, 32'hC));
        vecs.push_back(mk(2'b00, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11,
            32'h10, 32'h99, 32'h5, 32'h48, 32'h4C, 32'h77, 1'b0, 32'h4D, 32'h15, 32'h77));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,
            32'd5, 32'd5, 32'h10, 32'h100, 32'h104, 32'h0, 1'b1, 32'h110, 32'h0, 32'd5));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,
            32'd5, 32'd6, 32'h10, 32'h100, 32'h104, 32'h0, 1'b0, 32'h110, 32'hFFFFFFFF, 32'd6));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
            32'd5, 32'd5, 32'h10, 32'h100, 32'h104, 32'h0, 1'b0, 32'h110, 32'h0, 32'd5));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12,
            32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h200, 32'h204, 32'h0, 1'b0, 32'h200,
            32'hF000F000, 32'hFF00FF00));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13,
            32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h204, 32'h208, 32'h0, 1'b0, 32'h204,
            32'hFFFFFFFF, 32'h0F0F0F0F));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14,
            32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h208, 32'h20C, 32'h0, 1'b0, 32'h208,
            32'hFFFFFFFF, 32'h0F0F0F0F));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15,
            32'hFFFFFFFF, 32'd1, 32'h0, 32'h20C, 32'h210, 32'h0, 1'b0, 32'h20C, 32'd1, 32'd1));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16,
            32'hFFFFFFFF, 32'd1, 32'h0, 32'h210, 32'h214, 32'h0, 1'b0, 32'h210, 32'd0, 32'd1));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 5'd17,
            32'd1, 32'hFFFFFFFF, 32'h0, 32'h214, 32'h218, 32'h0, 1'b0, 32'h214, 32'd0,
            32'hFFFFFFFF));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 5'd18,
            32'd1, 32'hFFFFFFFF, 32'h0, 32'h218, 32'h21C, 32'h0, 1'b0, 32'h218, 32'd1,
            32'hFFFFFFFF));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd19,
            32'hFFFFFFFF, 32'd1, 32'h0, 32'h21C, 32'h220, 32'h0, 1'b0, 32'h21C, 32'd0, 32'd1));
        vecs.push_back(mk(2'b00, 2'b00, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31,
            32'h1234, 32'h5678, 32'd8, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 32'h4, 32'd0,
            32'h5678));
        vecs.push_back(mk(2'b11, 2'b11, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20,
            32'd7, 32'd2, 32'h0, 32'h300, 32'h304, 32'h55, 1'b0, 32'h300, 32'd5, 32'd2));
        vecs.push_back(mk(2'b01, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd21,
            32'd100, 32'd200, 32'h0, 32'h304, 32'h308, 32'd3, 1'b0, 32'h304, 32'd6, 32'd3));

        // Reset held with inputs toggling across several edges.
        rst = 1'b1;
        randomize_inputs();
        #1;
        check_m_zero("reset_initial");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            randomize_inputs();
            @(posedge clk);
            #1;
            check({"reset_hold ALU_ResultM"}, ALU_ResultM, 32'h0);
            check({"reset_hold PCPlus4M"}, PCPlus4M, 32'h0);
        end
        // Combinational target is not reset.
        PCE = 32'h1000; Imm_Ext_E = 32'h24;
        #1;
        check("reset PCTargetE live", PCTargetE, 32'h1024);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_m_zero("release_before_edge");

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            apply(v);
            #1;
            check($sformatf("v%0d PCSrcE", i), 32'(PCSrcE), 32'(v.exp_pcsrc));
            check($sformatf("v%0d PCTargetE", i), PCTargetE, v.exp_target);
            @(posedge clk);
            #1;
            check($sformatf("v%0d ALU_ResultM", i), ALU_ResultM, v.exp_alu);
            check($sformatf("v%0d WriteDataM", i), WriteDataM, v.exp_wd);
            check($sformatf("v%0d RegWriteM", i), 32'(RegWriteM), 32'(v.rw));
            check($sformatf("v%0d MemWriteM", i), 32'(MemWriteM), 32'(v.mw));
            check($sformatf("v%0d ResultSrcM", i), 32'(ResultSrcM), 32'(v.rs));
            check($sformatf("v%0d RD_M", i), 32'(RD_M), 32'(v.rd));
            check($sformatf("v%0d PCPlus4M", i), PCPlus4M, v.pc4);
        end

        // Mid-stream reset: registered outputs clear before the next edge.
        @(negedge clk);
        apply(vecs[0]);
        @(posedge clk);
        #1;
        check("pre_midreset ALU_ResultM", ALU_ResultM, 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check_m_zero("midreset");
        @(posedge clk);
        #1;
        check_m_zero("midreset_edge");

        // First capture happens on the first edge after release.
        @(negedge clk);
        rst = 1'b0;
        apply(vecs[8]);
        #1;
        check("post_release ALU_ResultM", ALU_ResultM, 32'h0);
        @(posedge clk);
        #1;
        check("first_capture ALU_ResultM", ALU_ResultM, 32'hF000F000);
        check("first_capture RD_M", 32'(RD_M), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute (EX) stage of the 5-stage RISC-V pipeline core.
- Selects forwarded operands and runs the ALU.
- Resolves branches and computes the branch target.
- Holds the EX/MEM pipeline register that feeds the memory stage.
- Sits between the decode stage (ID/EX register) and the memory stage; the hazard unit supplies the forwarding selects.

Parameters:
None. Data width is fixed at 32, register index at 5.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
RegWriteE  in  1  register-write enable from ID/EX
ALUSrcE  in  1  0: ALU B = forwarded rs2; 1: ALU B = Imm_Ext_E
MemWriteE  in  1  data-memory write enable
ResultSrcE  in  1  writeback select (passed through)
BranchE  in  1  instruction is a conditional branch (beq)
ALUControlE  in  3  ALU operation select
RD1_E  in  32  rs1 value from register file
RD2_E  in  32  rs2 value from register file
Imm_Ext_E  in  32  sign-extended immediate
RD_E  in  5  destination register index
PCE  in  32  PC of instruction in EX
PCPlus4E  in  32  PC+4 of instruction in EX
ResultW  in  32  writeback-stage result (forward source)
ForwardA_E  in  2  rs1 forward select
ForwardB_E  in  2  rs2 forward select
PCSrcE  out  1  take branch (combinational)
PCTargetE  out  32  branch target (combinational)
RegWriteM  out  1  registered RegWriteE
MemWriteM  out  1  registered MemWriteE
ResultSrcM  out  1  registered ResultSrcE
RD_M  out  5  registered RD_E
PCPlus4M  out  32  registered PCPlus4E
WriteDataM  out  32  registered forwarded rs2 (store data)
ALU_ResultM  out  32  registered ALU result

Behaviour:
Forward muxes (combinational):
- SrcA: ForwardA_E 00 -> RD1_E; 01 -> ResultW; 10 -> ALU_ResultM; 11 -> RD1_E.
- FwdB: same encoding applied to RD2_E.
- SrcB = ALUSrcE ? Imm_Ext_E : FwdB.

ALU (combinational, 32-bit, wrap-around, no exceptions):
- 000 add
- 001 sub (SrcA - SrcB)
- 010 and
- 011 or
- 100 xor
- 101 slt signed: result 1 if SrcA < SrcB as two's complement, else 0
- 110 sltu unsigned: 1 or 0 likewise
- 111 result 0
- Zero = (ALU result == 0).

Branch and target:
- PCSrcE = BranchE & Zero. The decoder drives sub (001) for beq.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^32, always computed regardless of BranchE.

EX/MEM register:
- On each rising clk edge, when rst is low, capture RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, FwdB (into WriteDataM) and the ALU result (into ALU_ResultM).
- Latency is 1 cycle; no stall or flush inputs (flush handled upstream).
- While rst is high, all registered outputs are forced to 0 immediately (asynchronous) and held at 0. This applies mid-operation too: in-flight EX/MEM content is discarded.
- The first capture occurs on the first rising edge after rst falls.

Other rules:
- PCSrcE and PCTargetE are not reset; they follow the inputs combinationally.
- Forwarding from ALU_ResultM uses the currently registered value. Its self-loop is legal because it passes through the register.
- ForwardA_E and ForwardB_E are independent. Both may select the same source simultaneously.

Test Plan:
1. Reset behaviour:
   - rst=1 with arbitrary inputs toggling -> all M outputs 0.
   - Assert rst mid-stream -> outputs drop to 0 before the next clk edge.
2. Register add:
   - RD1_E=5, RD2_E=3, ALUControlE=000, ALUSrcE=0, RegWriteE=1, RD_E=7 -> after one edge ALU_ResultM=8, WriteDataM=3, RegWriteM=1, RD_M=7.
   - Then ALUSrcE=1, Imm_Ext_E=3 -> ALU_ResultM=8, WriteDataM=3.
3. Forwarding:
   - ForwardA_E=01, ResultW=0xA, RD1_E=8, RD2_E=2, add -> ALU_ResultM=0xC.
   - Next, ForwardA_E=10, ForwardB_E=10 -> ALU_ResultM=0x18.
   - ForwardB_E=01 with ALUSrcE=1 -> WriteDataM=ResultW while the ALU uses the immediate.
4. Branch:
   - RD1_E=RD2_E=5, ALUControlE=001, BranchE=1, PCE=0x100, Imm_Ext_E=0x10 -> PCSrcE=1, PCTargetE=0x110.
   - RD2_E=6 -> PCSrcE=0.
   - BranchE=0 with equal operands -> PCSrcE=0.
5. Logic ops:
   - and 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
   - or 0xF0F0F0F0 | 0x0F0F0F0F -> 0xFFFFFFFF.
   - xor of the same two operands -> 0xFFFFFFFF.
6. Compare/wrap:
   - slt -1 vs 1 -> 1; sltu 0xFFFFFFFF vs 1 -> 0.
   - add 0xFFFFFFFF+1 -> 0.
   - PCTargetE 0xFFFFFFFC+8 -> 0x4.
